// File: rtl/tile_scheduler_pkg.sv
// Shared types and sizing for the tile scheduler: array geometry, FSM state
// encoding, dataflow mode encoding and the tile command record.
package tile_scheduler_pkg;

  // Geometry of the small systolic array.
  localparam int SMALL_SYS_ROWS = 8;
  localparam int SMALL_SYS_COLS = 8;

  // Default width of job sizes and tile offset/length fields.
  localparam int TS_DIM_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } tile_state_e;

  typedef enum logic [1:0] {
    MODE_WIDE_DEEP = 2'b00,
    MODE_VERT      = 2'b01,
    MODE_TALL_WIDE = 2'b10,
    MODE_TALL      = 2'b11
  } mode_e;

  // One tile command as presented to the array.
  typedef struct packed {
    logic [TS_DIM_W-1:0] k_off;
    logic [TS_DIM_W-1:0] k_len;
    logic [TS_DIM_W-1:0] n_off;
    logic [TS_DIM_W-1:0] n_len;
    logic                acc_clr;
    logic                last_k;
  } tile_cmd_t;

endpackage

// File: rtl/tile_scheduler_decode.sv
// Dataflow decoder: picks the array mode and operand mux selects from the
// job shape. A job is "tall" when its reduction fits in one tile's rows and
// "wide" when its output columns span more than one tile.
module tile_scheduler_decode
  import tile_scheduler_pkg::*;
#(
  parameter int DIM_W    = TS_DIM_W,
  parameter int SYS_ROWS = SMALL_SYS_ROWS,
  parameter int SYS_COLS = SMALL_SYS_COLS
) (
  input  logic [DIM_W-1:0] ksize,
  input  logic [DIM_W-1:0] nsize,
  output mode_e            mode,
  output logic             if_mux_sel,
  output logic             w_mux_sel
);

  localparam logic [DIM_W:0] ROWS_X = (DIM_W+1)'(SYS_ROWS);
  localparam logic [DIM_W:0] COLS_X = (DIM_W+1)'(SYS_COLS);

  logic tall;
  logic wide;

  assign tall = ({1'b0, ksize} <= ROWS_X);
  assign wide = ({1'b0, nsize} >  COLS_X);

  // Shape to mode/mux table; deep jobs stream input features, tall ones weights.
  always_comb begin
    mode       = MODE_TALL;
    if_mux_sel = 1'b0;
    w_mux_sel  = 1'b1;
    case ({tall, wide})
      2'b01: begin mode = MODE_WIDE_DEEP; if_mux_sel = 1'b1; w_mux_sel = 1'b0; end
      2'b00: begin mode = MODE_VERT;      if_mux_sel = 1'b1; w_mux_sel = 1'b0; end
      2'b11: begin mode = MODE_TALL_WIDE; if_mux_sel = 1'b0; w_mux_sel = 1'b1; end
      default: begin mode = MODE_TALL;    if_mux_sel = 1'b0; w_mux_sel = 1'b1; end
    endcase
  end

endmodule

// File: rtl/tile_scheduler.sv
// Job-level controller for the small systolic array. Accepts a GEMM job,
// latches its dataflow configuration and walks the job tile by tile
// (n-tiles outer, k-tiles inner), waiting for the array after every tile.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. start_ready is high only in IDLE. tile_valid, once raised,
// stays high with every tile field stable until tile_ready is seen (or the
// job is aborted / reset).
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int DIM_W    = TS_DIM_W,
  parameter int SYS_ROWS = SMALL_SYS_ROWS,
  parameter int SYS_COLS = SMALL_SYS_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [DIM_W-1:0] ksize,
  input  logic [DIM_W-1:0] nsize,
  input  logic             abort,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] tile_k_off,
  output logic [DIM_W-1:0] tile_k_len,
  output logic [DIM_W-1:0] tile_n_off,
  output logic [DIM_W-1:0] tile_n_len,
  output logic             tile_acc_clr,
  output logic             tile_last_k,
  input  logic             array_done,
  output logic [1:0]       mode,
  output logic             if_mux_sel,
  output logic             w_mux_sel,
  output logic             busy,
  output logic             job_done,
  output logic             err,
  output tile_state_e      dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  // One extra bit so offset + tile extent never wraps (e.g. 24 + 8 vs 31).
  localparam logic [DIM_W:0] ROWS_X = (DIM_W+1)'(SYS_ROWS);
  localparam logic [DIM_W:0] COLS_X = (DIM_W+1)'(SYS_COLS);

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] ksize_q, ksize_d;
  logic [DIM_W-1:0] nsize_q, nsize_d;
  logic [DIM_W-1:0] k_off_q, k_off_d;
  logic [DIM_W-1:0] n_off_q, n_off_d;
  logic [1:0]       mode_q, mode_d;
  logic             if_sel_q, if_sel_d;
  logic             w_sel_q, w_sel_d;
  logic             err_q, err_d;

  mode_e            dec_mode;
  logic             dec_if_sel;
  logic             dec_w_sel;

  logic [DIM_W:0]   ksize_x, nsize_x, k_off_x, n_off_x;
  logic [DIM_W:0]   k_next_x, n_next_x, k_rem_x, n_rem_x;
  logic             last_k, last_n;
  tile_cmd_t        cmd;

  // Decoder sees the live request sizes; its result is captured at the handshake.
  tile_scheduler_decode #(
    .DIM_W    (DIM_W),
    .SYS_ROWS (SYS_ROWS),
    .SYS_COLS (SYS_COLS)
  ) u_decode (
    .ksize      (ksize),
    .nsize      (nsize),
    .mode       (dec_mode),
    .if_mux_sel (dec_if_sel),
    .w_mux_sel  (dec_w_sel)
  );

  assign ksize_x  = {1'b0, ksize_q};
  assign nsize_x  = {1'b0, nsize_q};
  assign k_off_x  = {1'b0, k_off_q};
  assign n_off_x  = {1'b0, n_off_q};
  assign k_next_x = k_off_x + ROWS_X;
  assign n_next_x = n_off_x + COLS_X;
  assign k_rem_x  = ksize_x - k_off_x;
  assign n_rem_x  = nsize_x - n_off_x;
  assign last_k   = (k_next_x >= ksize_x);
  assign last_n   = (n_next_x >= nsize_x);

  // Tile command fields; held at zero whenever no command is being offered.
  always_comb begin
    cmd = '0;
    if (state_q == S_ISSUE) begin
      cmd.k_off   = k_off_q;
      cmd.k_len   = (k_rem_x > ROWS_X) ? ROWS_X[DIM_W-1:0] : k_rem_x[DIM_W-1:0];
      cmd.n_off   = n_off_q;
      cmd.n_len   = (n_rem_x > COLS_X) ? COLS_X[DIM_W-1:0] : n_rem_x[DIM_W-1:0];
      cmd.acc_clr = (k_off_q == '0);
      cmd.last_k  = last_k;
    end
  end

  // Next-state, counter, configuration and error logic.
  always_comb begin
    state_d  = state_q;
    ksize_d  = ksize_q;
    nsize_d  = nsize_q;
    k_off_d  = k_off_q;
    n_off_d  = n_off_q;
    mode_d   = mode_q;
    if_sel_d = if_sel_q;
    w_sel_d  = w_sel_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        // abort is meaningless here; a stray array_done flags an error.
        if (start_valid) begin
          ksize_d  = ksize;
          nsize_d  = nsize;
          k_off_d  = '0;
          n_off_d  = '0;
          mode_d   = dec_mode;
          if_sel_d = dec_if_sel;
          w_sel_d  = dec_w_sel;
          err_d    = 1'b0;
          if ((ksize == '0) || (nsize == '0)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        if (array_done) err_d = 1'b1;
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (array_done) err_d = 1'b1;
          if (tile_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (array_done) begin
          if (last_k && last_n) begin
            state_d = S_DONE;
          end else if (last_k) begin
            k_off_d = '0;
            n_off_d = n_next_x[DIM_W-1:0];
            state_d = S_ISSUE;
          end else begin
            k_off_d = k_next_x[DIM_W-1:0];
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        // S_DONE: one-cycle completion pulse, always back to IDLE.
        if (!abort && array_done) err_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ksize_q  <= '0;
      nsize_q  <= '0;
      k_off_q  <= '0;
      n_off_q  <= '0;
      mode_q   <= '0;
      if_sel_q <= 1'b0;
      w_sel_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ksize_q  <= ksize_d;
      nsize_q  <= nsize_d;
      k_off_q  <= k_off_d;
      n_off_q  <= n_off_d;
      mode_q   <= mode_d;
      if_sel_q <= if_sel_d;
      w_sel_q  <= w_sel_d;
      err_q    <= err_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign tile_valid   = (state_q == S_ISSUE);
  assign job_done     = (state_q == S_DONE);
  assign tile_k_off   = cmd.k_off;
  assign tile_k_len   = cmd.k_len;
  assign tile_n_off   = cmd.n_off;
  assign tile_n_len   = cmd.n_len;
  assign tile_acc_clr = cmd.acc_clr;
  assign tile_last_k  = cmd.last_k;
  assign mode         = mode_q;
  assign if_mux_sel   = if_sel_q;
  assign w_mux_sel    = w_sel_q;
  assign err          = err_q;
  assign dbg_state    = tile_state_e'(state_q);

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler with an 8x8 array: a table of jobs run end to end
// against a queue of expected tile commands, plus hand-written sequences for
// stray array_done, abort and mid-job reset.
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  localparam int DIM_W = 5;
  localparam int R = 8;
  localparam int C = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [DIM_W-1:0] ksize;
  logic [DIM_W-1:0] nsize;
  logic             abort;
  logic             tile_valid;
  logic             tile_ready;
  logic [DIM_W-1:0] tile_k_off;
  logic [DIM_W-1:0] tile_k_len;
  logic [DIM_W-1:0] tile_n_off;
  logic [DIM_W-1:0] tile_n_len;
  logic             tile_acc_clr;
  logic             tile_last_k;
  logic             array_done;
  logic [1:0]       mode;
  logic             if_mux_sel;
  logic             w_mux_sel;
  logic             busy;
  logic             job_done;
  logic             err;
  tile_state_e      dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [21:0] exp_q[$];

  typedef struct {
    int         ksize;
    int         nsize;
    logic [1:0] mode;
    logic       ifs;
    logic       ws;
    int         stall_tile;
    int         stall_cyc;
  } vec_t;

  vec_t vecs[7];

  // Clock block.
  always #5 clk = ~clk;

  tile_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .ksize        (ksize),
    .nsize        (nsize),
    .abort        (abort),
    .tile_valid   (tile_valid),
    .tile_ready   (tile_ready),
    .tile_k_off   (tile_k_off),
    .tile_k_len   (tile_k_len),
    .tile_n_off   (tile_n_off),
    .tile_n_len   (tile_n_len),
    .tile_acc_clr (tile_acc_clr),
    .tile_last_k  (tile_last_k),
    .array_done   (array_done),
    .mode         (mode),
    .if_mux_sel   (if_mux_sel),
    .w_mux_sel    (w_mux_sel),
    .busy         (busy),
    .job_done     (job_done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [21:0] pack_tile(input int ko, input int kl, input int no,
                                            input int nl, input bit ac, input bit lk);
    return {5'(ko), 5'(kl), 5'(no), 5'(nl), ac, lk};
  endfunction

  function automatic logic [21:0] act_tile();
    return {tile_k_off, tile_k_len, tile_n_off, tile_n_len, tile_acc_clr, tile_last_k};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    start_valid = 1'b0;
    tile_ready = 1'b0;
    array_done = 1'b0;
    abort = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Accept a job on the next edge; afterwards the size inputs are scrambled
  // so that latching at the handshake is exercised.
  task automatic start_job(input int k, input int n);
    start_valid = 1'b1;
    ksize = 5'(k);
    nsize = 5'(n);
    tick();
    start_valid = 1'b0;
    ksize = 5'($urandom_range(0, 31));
    nsize = 5'($urandom_range(0, 31));
  endtask

  // Accept the offered tile, then finish it 3 cycles after the accept.
  task automatic accept_and_finish();
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check("wait_no_valid", 32'(tile_valid), 32'd0);
    repeat (2) tick();
    array_done = 1'b1;
    tick();
    array_done = 1'b0;
  endtask

  // Run a whole job from the table against the expected-tile queue.
  task automatic run_job(input vec_t v);
    logic [21:0] exp;
    int idx;
    bit zero;
    zero = (v.ksize == 0) || (v.nsize == 0);
    for (int n = 0; n < v.nsize; n += C)
      for (int k = 0; k < v.ksize; k += R)
        exp_q.push_back(pack_tile(k, (v.ksize - k < R) ? v.ksize - k : R,
                                  n, (v.nsize - n < C) ? v.nsize - n : C,
                                  k == 0, k + R >= v.ksize));
    check("start_ready", 32'(start_ready), 32'd1);
    start_job(v.ksize, v.nsize);
    check("mode", 32'(mode), 32'(v.mode));
    check("if_mux_sel", 32'(if_mux_sel), 32'(v.ifs));
    check("w_mux_sel", 32'(w_mux_sel), 32'(v.ws));
    check("err_after_start", 32'(err), zero ? 32'd1 : 32'd0);
    check("start_ready_busy", 32'(start_ready), 32'd0);
    if (zero) begin
      check("zero_no_tile", 32'(tile_valid), 32'd0);
      check("zero_job_done", 32'(job_done), 32'd1);
      tick();
      check("zero_job_done_pulse", 32'(job_done), 32'd0);
      check("zero_idle", 32'(busy), 32'd0);
      check("zero_err_sticky", 32'(err), 32'd1);
      return;
    end
    idx = 0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("tile_valid", 32'(tile_valid), 32'd1);
      if (tile_valid !== 1'b1) begin
        exp_q.delete();
        do_reset();
        return;
      end
      check("tile_fields", 32'(act_tile()), 32'(exp));
      if (idx == v.stall_tile) begin
        for (int s = 0; s < v.stall_cyc; s++) begin
          tick();
          check("stall_valid", 32'(tile_valid), 32'd1);
          check("stall_fields", 32'(act_tile()), 32'(exp));
        end
      end
      accept_and_finish();
      idx++;
    end
    check("job_done", 32'(job_done), 32'd1);
    check("job_err", 32'(err), 32'd0);
    check("no_extra_tile", 32'(tile_valid), 32'd0);
    tick();
    check("job_done_pulse", 32'(job_done), 32'd0);
    check("idle_after_job", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset block.
    rst = 1'b0;
    start_valid = 1'b0;
    ksize = '0;
    nsize = '0;
    abort = 1'b0;
    tile_ready = 1'b0;
    array_done = 1'b0;
    repeat (2) tick();
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tile_valid", 32'(tile_valid), 32'd0);
    check("rst_tile_fields", 32'(act_tile()), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_sels", 32'({if_mux_sel, w_mux_sel}), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_job_done", 32'(job_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    tick();

    // Job table: sizes, expected mode/if/w, tile index to stall and how long.
    vecs[0] = '{20, 12, 2'b00, 1'b1, 1'b0, -1, 0};
    vecs[1] = '{4,  4,  2'b11, 1'b0, 1'b1, -1, 0};
    vecs[2] = '{8,  9,  2'b10, 1'b0, 1'b1, -1, 0};
    vecs[3] = '{31, 8,  2'b01, 1'b1, 1'b0,  1, 5};
    vecs[4] = '{0,  5,  2'b11, 1'b0, 1'b1, -1, 0};
    vecs[5] = '{9,  31, 2'b00, 1'b1, 1'b0,  3, 2};
    vecs[6] = '{8,  8,  2'b11, 1'b0, 1'b1, -1, 0};
    for (int i = 0; i < 7; i++) run_job(vecs[i]);

    // array_done in IDLE flags an error without leaving IDLE; abort in IDLE is ignored.
    array_done = 1'b1;
    tick();
    array_done = 1'b0;
    check("idle_done_err", 32'(err), 32'd1);
    check("idle_done_state", 32'(dbg_state), 32'(ST_IDLE));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_mode", 32'(mode), 32'b11);

    // array_done in ISSUE flags an error and does not advance; then abort in WAIT.
    start_job(20, 4);
    check("abort_job_err_clr", 32'(err), 32'd0);
    check("abort_job_mode", 32'(mode), 32'b01);
    array_done = 1'b1;
    tick();
    array_done = 1'b0;
    check("issue_done_err", 32'(err), 32'd1);
    check("issue_done_valid", 32'(tile_valid), 32'd1);
    check("issue_done_noadv", 32'(act_tile()), 32'(pack_tile(0, 8, 0, 4, 1'b1, 1'b0)));
    accept_and_finish();
    check("tile2_valid", 32'(tile_valid), 32'd1);
    check("tile2_fields", 32'(act_tile()), 32'(pack_tile(8, 8, 0, 4, 1'b0, 1'b0)));
    tile_ready = 1'b1;
    tick();
    tile_ready = 1'b0;
    check("tile2_wait", 32'(dbg_state), 32'(ST_WAIT));
    abort = 1'b1;
    array_done = 1'b1;
    tick();
    abort = 1'b0;
    array_done = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_valid", 32'(tile_valid), 32'd0);
    check("abort_no_done", 32'(job_done), 32'd0);
    check("abort_mode_kept", 32'({mode, if_mux_sel, w_mux_sel}), 32'b0110);
    check("abort_err_kept", 32'(err), 32'd1);
    repeat (3) begin
      tick();
      check("abort_quiet", 32'({job_done, tile_valid, busy}), 32'd0);
    end

    // Asynchronous reset in the middle of ISSUE.
    start_job(31, 8);
    check("pre_rst_valid", 32'(tile_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(tile_valid), 32'd0);
    check("arst_start_ready", 32'(start_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cfg", 32'({mode, if_mux_sel, w_mux_sel}), 32'd0);
    check("arst_fields", 32'(act_tile()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Normal operation after reset.
    run_job(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
